acl2_tilt_filter: RTL and testbench



---
 rtl/acl2_tilt_filter.sv | 155 +++++++++++++++
 tb/tb_acl2_tilt_filter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/acl2_tilt_filter.sv
// acl2_tilt_filter: samples the ACL2 axes into clk, moving-averages each axis and classifies tilt.
// Optional macro TILT_HYST_EN: use TILT_OFF as a lower exit threshold (tilt hysteresis).
module acl2_tilt_filter #(
  parameter logic [15:0]        SAMPLE_DIV = 16'd50000,
  parameter int unsigned        LOG2_N     = 3,
  parameter logic signed [11:0] TILT_ON    = 12'sd300,
  parameter logic signed [11:0] TILT_OFF   = 12'sd200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] acc_x,
  input  logic [11:0] acc_y,
  input  logic [11:0] acc_z,
  output logic [11:0] avg_x,
  output logic [11:0] avg_y,
  output logic [11:0] avg_z,
  output logic        avg_valid,
  output logic [2:0]  tilt,
  output logic        tilt_changed
);
  localparam int unsigned AW = 12;
  localparam int unsigned N  = 1 << LOG2_N;
  localparam int unsigned SW = AW + LOG2_N;
  localparam int unsigned MW = AW + 1;

  localparam logic [2:0] T_FLAT  = 3'd0;
  localparam logic [2:0] T_RIGHT = 3'd1;
  localparam logic [2:0] T_LEFT  = 3'd2;
  localparam logic [2:0] T_UP    = 3'd3;
  localparam logic [2:0] T_DOWN  = 3'd4;

  localparam logic signed [MW-1:0] ON_M = MW'(TILT_ON);
`ifdef TILT_HYST_EN
  localparam logic signed [MW-1:0] HOLD_M = MW'(TILT_OFF);
`else
  localparam logic signed [MW-1:0] HOLD_M = ON_M;
`endif

  // Elaboration-time parameter legality checks
  if (SAMPLE_DIV < 16'd8) begin : g_bad_div
    $error("acl2_tilt_filter: SAMPLE_DIV must be at least 8");
  end
  if (TILT_OFF > TILT_ON) begin : g_bad_thr
    $error("acl2_tilt_filter: TILT_OFF must not exceed TILT_ON");
  end

  typedef enum logic [1:0] {IDLE, CAPTURE, ACCUM, UPDATE} state_t;

  state_t                       state;
  logic [15:0]                  div_cnt;
  logic                         tick;
  logic [2:0][AW-1:0]           s1, s2, samp, avg;
  logic [2:0][SW-1:0]           sum, sum_nxt;
  logic [2:0][N-1:0][AW-1:0]    hist;
  logic [LOG2_N-1:0]            ptr;
  logic signed [MW-1:0]         m_right, m_left, m_up, m_down, cur_m;
  logic                         cur_live;
  logic [2:0]                   tilt_nxt;

  assign avg_x = avg[0];
  assign avg_y = avg[1];
  assign avg_z = avg[2];

  // Free-running sample divider; never stalls
  assign tick = (div_cnt == SAMPLE_DIV - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 16'd1;
  end

  // Two-flop synchronizer; s1 == s2 marks a settled sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {acc_z, acc_y, acc_x};
      s2 <= s1;
    end
  end

  always_comb begin
    for (int a = 0; a < 3; a++) begin
      sum_nxt[a] = SW'($signed(sum[a]) + SW'($signed(samp[a])) - SW'($signed(hist[a][ptr])));
    end
  end

  assign m_right = MW'($signed(avg[0]));
  assign m_left  = -m_right;
  assign m_up    = MW'($signed(avg[1]));
  assign m_down  = -m_up;

  // Current direction holds while its metric stays above the exit threshold
  always_comb begin
    cur_m    = '0;
    cur_live = 1'b1;
    case (tilt)
      T_RIGHT: cur_m = m_right;
      T_LEFT:  cur_m = m_left;
      T_UP:    cur_m = m_up;
      T_DOWN:  cur_m = m_down;
      default: cur_live = 1'b0;
    endcase
    tilt_nxt = T_FLAT;
    if (cur_live && cur_m >= HOLD_M) tilt_nxt = tilt;
    else if (m_right >= ON_M)        tilt_nxt = T_RIGHT;
    else if (m_left  >= ON_M)        tilt_nxt = T_LEFT;
    else if (m_up    >= ON_M)        tilt_nxt = T_UP;
    else if (m_down  >= ON_M)        tilt_nxt = T_DOWN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      samp         <= '0;
      sum          <= '0;
      hist         <= '0;
      avg          <= '0;
      ptr          <= '0;
      avg_valid    <= 1'b0;
      tilt         <= T_FLAT;
      tilt_changed <= 1'b0;
    end else begin
      avg_valid    <= 1'b0;
      tilt_changed <= 1'b0;
      case (state)
        IDLE: if (tick) state <= CAPTURE;
        CAPTURE: begin
          if (s1 == s2) begin
            samp  <= s2;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          for (int a = 0; a < 3; a++) begin
            sum[a]       <= sum_nxt[a];
            hist[a][ptr] <= samp[a];
            avg[a]       <= AW'($signed(sum_nxt[a]) >>> LOG2_N);
          end
          ptr       <= ptr + LOG2_N'(1);
          avg_valid <= 1'b1;
          state     <= UPDATE;
        end
        UPDATE: begin
          tilt         <= tilt_nxt;
          tilt_changed <= (tilt_nxt != tilt);
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acl2_tilt_filter.sv
// Randomized bench for acl2_tilt_filter against a sliding-window average / tilt-rule model.
`timescale 1ns/1ps
module tb_acl2_tilt_filter;
  localparam int DEPTH   = 8;
  localparam int ON_THR  = 300;
  localparam int OFF_THR = 200;
`ifdef TILT_HYST_EN
  localparam bit HYST = 1'b1;
`else
  localparam bit HYST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] acc_x, acc_y, acc_z;
  logic [11:0] avg_x, avg_y, avg_z;
  logic        avg_valid;
  logic [2:0]  tilt;
  logic        tilt_changed;

  acl2_tilt_filter #(
    .SAMPLE_DIV(16'd16),
    .LOG2_N    (3),
    .TILT_ON   (12'sd300),
    .TILT_OFF  (12'sd200)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .acc_x       (acc_x),
    .acc_y       (acc_y),
    .acc_z       (acc_z),
    .avg_x       (avg_x),
    .avg_y       (avg_y),
    .avg_z       (avg_z),
    .avg_valid   (avg_valid),
    .tilt        (tilt),
    .tilt_changed(tilt_changed)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int mhist[3][DEPTH];
  int mptr;
  int mtilt;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int floor_div(input int s);
    int q;
    q = s / DEPTH;
    if ((s % DEPTH != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic int ref_tilt(input int cur, input int ax, input int ay);
    int m[5];
    int hold_thr;
    m[0] = 0; m[1] = ax; m[2] = -ax; m[3] = ay; m[4] = -ay;
    hold_thr = HYST ? OFF_THR : ON_THR;
    if (cur != 0 && m[cur] >= hold_thr) return cur;
    for (int k = 1; k <= 4; k++) if (m[k] >= ON_THR) return k;
    return 0;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 3; a++)
      for (int i = 0; i < DEPTH; i++) mhist[a][i] = 0;
    mptr  = 0;
    mtilt = 0;
  endtask

  // Called in the avg_valid cycle; consumes the following cycle for tilt
  task automatic check_pulse(input string tag);
    int v[3];
    int e[3];
    int s;
    int nt;
    v[0] = int'($signed(acc_x));
    v[1] = int'($signed(acc_y));
    v[2] = int'($signed(acc_z));
    for (int a = 0; a < 3; a++) mhist[a][mptr] = v[a];
    mptr = (mptr + 1) % DEPTH;
    for (int a = 0; a < 3; a++) begin
      s = 0;
      for (int i = 0; i < DEPTH; i++) s += mhist[a][i];
      e[a] = floor_div(s);
    end
    check({tag, ".avg_x"}, int'($signed(avg_x)), e[0]);
    check({tag, ".avg_y"}, int'($signed(avg_y)), e[1]);
    check({tag, ".avg_z"}, int'($signed(avg_z)), e[2]);
    nt = ref_tilt(mtilt, e[0], e[1]);
    step();
    check({tag, ".valid_width"}, int'(avg_valid), 0);
    check({tag, ".tilt"}, int'(tilt), nt);
    check({tag, ".tilt_changed"}, int'(tilt_changed), int'(nt != mtilt));
    mtilt = nt;
  endtask

  task automatic run_pulse(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      step();
      if (avg_valid) ok = 1'b1;
    end
    if (ok) check_pulse(tag);
    else    check({tag, ".timeout"}, 0, 1);
  endtask

  function automatic logic [11:0] rand_axis(input logic [11:0] cur);
    int v;
    case ($urandom_range(0, 3))
      0: v = int'($urandom_range(0, 4095)) - 2048;
      1: v = ($urandom_range(0, 1) != 0) ? int'($urandom_range(150, 450)) : -int'($urandom_range(150, 450));
      2: v = 0;
      default: v = int'($signed(cur));
    endcase
    return 12'(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    int dly;
    rst   = 1'b1;
    acc_x = '0;
    acc_y = '0;
    acc_z = '0;
    model_reset();
    repeat (3) step();
    check("rst.avg_x", int'(avg_x), 0);
    check("rst.avg_y", int'(avg_y), 0);
    check("rst.avg_z", int'(avg_z), 0);
    check("rst.avg_valid", int'(avg_valid), 0);
    check("rst.tilt", int'(tilt), 0);
    check("rst.tilt_changed", int'(tilt_changed), 0);
    rst = 1'b0;

    // Ramp toward RIGHT
    acc_x = 12'd400;
    for (int p = 1; p <= 8; p++) begin
      run_pulse("ramp");
      if (p == 1) check("ramp.first_avg", int'($signed(avg_x)), 50);
      if (p == 5) check("ramp.tilt5", int'(tilt), 0);
      if (p == 6) check("ramp.tilt6", int'(tilt), 1);
      if (p == 8) check("ramp.final_avg", int'($signed(avg_x)), 400);
    end

    // Release: hysteresis decides when RIGHT is dropped
    acc_x = 12'd0;
    for (int p = 1; p <= 8; p++) begin
      run_pulse("hyst");
      if (p == 3) check("hyst.tilt3", int'(tilt), HYST ? 1 : 0);
      if (p == 5) check("hyst.tilt5", int'(tilt), 0);
    end

    // Negative axis, floor rounding
    acc_y = 12'(-403);
    for (int p = 1; p <= 8; p++) begin
      run_pulse("neg");
      if (p == 1) check("neg.first_avg", int'($signed(avg_y)), -51);
      if (p == 6) check("neg.tilt6", int'(tilt), 4);
      if (p == 8) check("neg.final_avg", int'($signed(avg_y)), -403);
    end
    acc_y = 12'd0;
    for (int p = 1; p <= 8; p++) run_pulse("neg_rel");

    // Priority RIGHT over UP, then fall through to UP
    acc_x = 12'd400;
    acc_y = 12'd400;
    for (int p = 1; p <= 8; p++) run_pulse("prio");
    check("prio.tilt", int'(tilt), 1);
    acc_x = 12'd0;
    for (int p = 1; p <= 8; p++) run_pulse("prio_rel");
    check("prio_rel.tilt", int'(tilt), 3);

    // Unstable input holds capture off
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      acc_z = acc_z ^ 12'd1;
      step();
      if (avg_valid) seen++;
    end
    check("stab.quiet", seen, 0);
    dly = -1;
    for (int i = 1; i <= 8 && dly < 0; i++) begin
      step();
      if (avg_valid) dly = i + 1;
    end
    check("stab.delay_ok", int'(dly >= 3 && dly <= 4), 1);
    if (dly > 0) check_pulse("stab");

    // Reset during ACCUM: 14 cycles after a regular pulse lands in the next ACCUM
    run_pulse("pre_rst");
    acc_x = 12'(-1000);
    repeat (14) step();
    rst = 1'b1;
    #1;
    check("midrst.avg_x", int'(avg_x), 0);
    check("midrst.avg_y", int'(avg_y), 0);
    check("midrst.avg_valid", int'(avg_valid), 0);
    check("midrst.tilt", int'(tilt), 0);
    check("midrst.tilt_changed", int'(tilt_changed), 0);
    repeat (2) step();
    rst = 1'b0;
    model_reset();
    run_pulse("post_rst");
    check("post_rst.first_avg", int'($signed(avg_x)), -125);

    // Randomized traffic
    for (int p = 0; p < 48; p++) begin
      acc_x = rand_axis(acc_x);
      acc_y = rand_axis(acc_y);
      acc_z = rand_axis(acc_z);
      run_pulse("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
